// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the IFU/LSU memory port arbiter
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 32;
  localparam int MEM_ARB_DATA_W = 32;
  localparam int MEM_ARB_MASK_W = MEM_ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IFU, LSU and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [ADDR_WIDTH-1:0]   ifu_addr;
  logic                    ifu_rsp_valid;
  logic [DATA_WIDTH-1:0]   ifu_rsp_data;

  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic                    lsu_wen;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [DATA_WIDTH/8-1:0] lsu_wmask;
  logic                    lsu_rsp_valid;
  logic [DATA_WIDTH-1:0]   lsu_rsp_data;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_wen;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wmask;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;

  logic                    proto_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output proto_err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  proto_err
  );

endinterface

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - IFU/LSU winner select; MEM_ARB_RR_EN selects round-robin over fixed LSU priority
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic accept_i,
`endif
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  output logic grant_lsu_o
);

`ifdef MEM_ARB_RR_EN
  arb_owner_e last_grant_q;

  // On conflict the side not granted last wins; a lone requester always wins.
  always_comb begin
    grant_lsu_o = lsu_valid_i;
    if (ifu_valid_i && lsu_valid_i) begin
      grant_lsu_o = (last_grant_q == OWN_IFU);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWN_IFU;
    end else if (accept_i) begin
      last_grant_q <= grant_lsu_o ? OWN_LSU : OWN_IFU;
    end
  end
`else
  assign grant_lsu_o = lsu_valid_i | ~ifu_valid_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding IFU/LSU memory port arbiter
// MEM_ARB_RR_EN: round-robin grant instead of fixed LSU priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ARB_ADDR_W,
  parameter int DATA_WIDTH = MEM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e              state_q;
  arb_owner_e              owner_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic                    wen_q;
  logic                    proto_err_q;

  logic accept;
  logic grant_lsu;
  logic rsp_hit;

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign accept  = (state_q == ARB_IDLE) && !rst && (bus.ifu_req_valid || bus.lsu_req_valid);
  assign rsp_hit = (state_q == ARB_RESP) && bus.mem_rsp_valid;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
`endif
    .ifu_valid_i (bus.ifu_req_valid),
    .lsu_valid_i (bus.lsu_req_valid),
    .grant_lsu_o (grant_lsu)
  );

  assign bus.ifu_req_ready = accept && !grant_lsu;
  assign bus.lsu_req_ready = accept && grant_lsu;

  assign bus.mem_req_valid = (state_q == ARB_REQ);
  assign bus.mem_wen       = wen_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  assign bus.ifu_rsp_valid = rsp_hit && (owner_q == OWN_IFU);
  assign bus.ifu_rsp_data  = bus.mem_rsp_data;
  assign bus.lsu_rsp_valid = rsp_hit && (owner_q == OWN_LSU);
  assign bus.lsu_rsp_data  = wen_q ? '0 : bus.mem_rsp_data;
  assign bus.proto_err     = proto_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IFU;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wen_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (bus.mem_rsp_valid && (state_q != ARB_RESP)) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            owner_q <= grant_lsu ? OWN_LSU : OWN_IFU;
            addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q   <= grant_lsu && bus.lsu_wen;
            wdata_q <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q <= (grant_lsu && bus.lsu_wen) ? bus.lsu_wmask : '0;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.mem_req_ready) begin
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (bus.mem_rsp_valid) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Memory model: accepts when mem_rdy, answers one cycle later when rsp_en.
  logic        mem_rdy;
  logic        rsp_en;
  logic        force_rsp;
  logic        rsp_pend;
  logic [31:0] rsp_data;

  assign bus.mem_req_ready = mem_rdy;
  assign bus.mem_rsp_valid = (rsp_pend & rsp_en) | force_rsp;
  assign bus.mem_rsp_data  = rsp_data;

  always @(posedge clk or posedge rst) begin
    if (rst) rsp_pend <= 1'b0;
    else     rsp_pend <= bus.mem_req_valid & bus.mem_req_ready;
  end

  logic [31:0] log_addr  [16];
  logic [31:0] log_wdata [16];
  logic [3:0]  log_wmask [16];
  logic        log_wen   [16];
  int          log_n = 0;

  always @(posedge clk) begin
    if (!rst && bus.mem_req_valid && bus.mem_req_ready && log_n < 16) begin
      log_addr[log_n]  <= bus.mem_addr;
      log_wdata[log_n] <= bus.mem_wdata;
      log_wmask[log_n] <= bus.mem_wmask;
      log_wen[log_n]   <= bus.mem_wen;
      log_n            <= log_n + 1;
    end
  end

  int          ifu_cnt = 0;
  int          lsu_cnt = 0;
  logic [31:0] last_ifu_data = '0;
  logic [31:0] last_lsu_data = '0;

  always @(posedge clk) begin
    if (bus.ifu_rsp_valid) begin
      ifu_cnt       <= ifu_cnt + 1;
      last_ifu_data <= bus.ifu_rsp_data;
    end
    if (bus.lsu_rsp_valid) begin
      lsu_cnt       <= lsu_cnt + 1;
      last_lsu_data <= bus.lsu_rsp_data;
    end
  end

  logic g_lsu [8];
  int   g_n;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_grants(input int n, input bit hold);
    int cyc;
    bit l;
    bit i;
    cyc = 0;
    g_n = 0;
    while (g_n < n && cyc < 200) begin
      @(negedge clk);
      l = bus.lsu_req_ready;
      i = bus.ifu_req_ready;
      if (l && i) begin
        bad++;
        $display("FAIL dual_grant: both req_ready=1 at cycle %0d, required at most one", cyc);
      end
      step();
      if (l) begin
        g_lsu[g_n] = 1'b1;
        g_n++;
        if (!hold) bus.lsu_req_valid = 1'b0;
      end else if (i) begin
        g_lsu[g_n] = 1'b0;
        g_n++;
        if (!hold) bus.ifu_req_valid = 1'b0;
      end
      cyc++;
    end
    total++;
    if (g_n != n) begin
      bad++;
      $display("FAIL grant_count: got %0d grants, required %0d", g_n, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready: ifu/lsu ready,mem_req_valid=%b required 000",
               {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid});
    end
    total++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.proto_err, bus.mem_wen} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: rsp valids,proto_err,wen=%b required 0000",
               {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.proto_err, bus.mem_wen});
    end
    total++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wmask !== 4'h0) begin
      bad++;
      $display("FAIL reset_fields: addr=%h wdata=%h wmask=%h required 0", bus.mem_addr, bus.mem_wdata,
               bus.mem_wmask);
    end
    step();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_ifu_only();
    int ic;
    int lc;
    ic = ifu_cnt;
    lc = lsu_cnt;
    rsp_data = 32'h0000_0013;
    bus.ifu_addr = 32'h8000_0000;
    bus.ifu_req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ifu_req_ready !== 1'b1 || bus.lsu_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ifu_c0_ready: ifu=%b lsu=%b required 1 0", bus.ifu_req_ready, bus.lsu_req_ready);
    end
    step();
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0000 ||
        bus.mem_wen !== 1'b0 || bus.mem_wmask !== 4'h0) begin
      bad++;
      $display("FAIL ifu_c1_req: valid=%b addr=%h wen=%b mask=%h required 1 80000000 0 0",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_data !== 32'h13 || bus.lsu_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL ifu_c2_rsp: ifu_v=%b data=%h lsu_v=%b required 1 00000013 0",
               bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.lsu_rsp_valid);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.ifu_rsp_valid !== 1'b0 || ifu_cnt != ic + 1 || lsu_cnt != lc) begin
      bad++;
      $display("FAIL ifu_pulse: ifu_v=%b ifu_cnt=%0d lsu_cnt=%0d required 0 %0d %0d",
               bus.ifu_rsp_valid, ifu_cnt, lsu_cnt, ic + 1, lc);
    end
    step();
  endtask

  task automatic test_conflict();
    int base;
    int lc;
    base = log_n;
    lc = lsu_cnt;
    rsp_data = 32'h0000_0093;
    bus.lsu_wen = 1'b1;
    bus.lsu_addr = 32'h0000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wmask = 4'hF;
    bus.ifu_addr = 32'h0000_2000;
    bus.lsu_req_valid = 1'b1;
    bus.ifu_req_valid = 1'b1;
    run_grants(2, 1'b0);
    repeat (4) step();
    total++;
    if (g_lsu[0] !== 1'b1 || g_lsu[1] !== 1'b0) begin
      bad++;
      $display("FAIL conflict_order: grants=%b%b required 10 (LSU then IFU)", g_lsu[0], g_lsu[1]);
    end
    total++;
    if (log_n != base + 2) begin
      bad++;
      $display("FAIL conflict_count: mem requests=%0d required %0d", log_n - base, 2);
    end
    total++;
    if (log_wen[base] !== 1'b1 || log_addr[base] !== 32'h1000 ||
        log_wdata[base] !== 32'hDEAD_BEEF || log_wmask[base] !== 4'hF) begin
      bad++;
      $display("FAIL conflict_lsu_write: wen=%b addr=%h data=%h mask=%h required 1 00001000 deadbeef f",
               log_wen[base], log_addr[base], log_wdata[base], log_wmask[base]);
    end
    total++;
    if (log_wen[base+1] !== 1'b0 || log_addr[base+1] !== 32'h2000 || log_wmask[base+1] !== 4'h0) begin
      bad++;
      $display("FAIL conflict_ifu_read: wen=%b addr=%h mask=%h required 0 00002000 0",
               log_wen[base+1], log_addr[base+1], log_wmask[base+1]);
    end
    total++;
    if (lsu_cnt != lc + 1 || last_lsu_data !== 32'h0 || last_ifu_data !== 32'h93) begin
      bad++;
      $display("FAIL conflict_rsp: lsu_cnt=%0d lsu_data=%h ifu_data=%h required %0d 0 00000093",
               lsu_cnt, last_lsu_data, last_ifu_data, lc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic exp_lsu [4];
`ifdef MEM_ARB_RR_EN
    exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    base = log_n;
    rsp_data = 32'h0BAD_F00D;
    bus.lsu_wen = 1'b0;
    bus.lsu_addr = 32'h0000_4000;
    bus.ifu_addr = 32'h0000_5000;
    bus.lsu_req_valid = 1'b1;
    bus.ifu_req_valid = 1'b1;
    run_grants(4, 1'b1);
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (g_lsu[k] !== exp_lsu[k] || log_addr[base+k] !== (exp_lsu[k] ? 32'h4000 : 32'h5000)) begin
        bad++;
        $display("FAIL b2b_grant%0d: lsu=%b addr=%h required lsu=%b", k, g_lsu[k], log_addr[base+k],
                 exp_lsu[k]);
      end
    end
    total++;
    if (last_lsu_data !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL b2b_load_data: %h required 0badf00d", last_lsu_data);
    end
  endtask

  task automatic test_stall();
    int lc;
    lc = lsu_cnt;
    mem_rdy = 1'b0;
    bus.lsu_wen = 1'b1;
    bus.lsu_addr = 32'h0000_6000;
    bus.lsu_wdata = 32'h55AA_55AA;
    bus.lsu_wmask = 4'h3;
    bus.ifu_addr = 32'h0000_7000;
    bus.lsu_req_valid = 1'b1;
    bus.ifu_req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.lsu_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_grant: lsu_req_ready=%b required 1", bus.lsu_req_ready);
    end
    step();
    bus.lsu_addr = 32'hFFFF_FFF0;
    bus.lsu_wdata = 32'h1234_5678;
    bus.lsu_wmask = 4'hC;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h6000 || bus.mem_wdata !== 32'h55AA_55AA ||
          bus.mem_wmask !== 4'h3 || bus.mem_wen !== 1'b1 ||
          bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_c%0d: v=%b addr=%h data=%h mask=%h wen=%b rdy=%b%b required 1 6000 55aa55aa 3 1 00",
                 c, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen,
                 bus.ifu_req_ready, bus.lsu_req_ready);
      end
      step();
    end
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b0;
    mem_rdy = 1'b1;
    repeat (4) step();
    total++;
    if (lsu_cnt != lc + 1) begin
      bad++;
      $display("FAIL stall_done: lsu_cnt=%0d required %0d", lsu_cnt, lc + 1);
    end
  endtask

  task automatic test_proto_err();
    int ic;
    int lc;
    ic = ifu_cnt;
    lc = lsu_cnt;
    total++;
    if (bus.proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_pre: proto_err=%b required 0", bus.proto_err);
    end
    force_rsp = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL proto_fwd: ifu_v=%b lsu_v=%b required 0 0", bus.ifu_rsp_valid, bus.lsu_rsp_valid);
    end
    step();
    force_rsp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.proto_err !== 1'b1) begin
        bad++;
        $display("FAIL proto_sticky%0d: proto_err=%b required 1", c, bus.proto_err);
      end
      step();
    end
    total++;
    if (ifu_cnt != ic || lsu_cnt != lc) begin
      bad++;
      $display("FAIL proto_cnt: ifu=%0d lsu=%0d required %0d %0d", ifu_cnt, lsu_cnt, ic, lc);
    end
  endtask

  task automatic test_reset_in_resp();
    int ic;
    ic = ifu_cnt;
    rsp_en = 1'b0;
    bus.ifu_addr = 32'h0000_7000;
    bus.ifu_req_valid = 1'b1;
    step();
    bus.ifu_req_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.proto_err !== 1'b0 ||
        bus.ifu_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: v=%b addr=%h perr=%b ifu_rdy=%b required 0 0 0 0",
               bus.mem_req_valid, bus.mem_addr, bus.proto_err, bus.ifu_req_ready);
    end
    step();
    bus.ifu_req_valid = 1'b0;
    rst = 1'b0;
    rsp_en = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mem_req_valid !== 1'b0 || bus.ifu_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle: mem_v=%b ifu_rsp_v=%b required 0 0", bus.mem_req_valid, bus.ifu_rsp_valid);
    end
    step();
    force_rsp = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ifu_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL late_rsp_fwd: ifu_rsp_valid=%b required 0", bus.ifu_rsp_valid);
    end
    step();
    force_rsp = 1'b0;
    @(negedge clk);
    total++;
    if (bus.proto_err !== 1'b1 || ifu_cnt != ic) begin
      bad++;
      $display("FAIL late_rsp_err: proto_err=%b ifu_cnt=%0d required 1 %0d", bus.proto_err, ifu_cnt, ic);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    mem_rdy = 1'b1;
    rsp_en = 1'b1;
    force_rsp = 1'b0;
    rsp_data = '0;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_wen = 1'b0;
    bus.lsu_addr = '0;
    bus.lsu_wdata = '0;
    bus.lsu_wmask = '0;

    test_reset();
    test_ifu_only();
    test_conflict();
    test_back_to_back();
    test_stall();
    test_proto_err();
    test_reset_in_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
